// File: rtl/odt_traverse_engine.sv
// Oblique decision-tree traversal engine: walks nodes held in an internal RAM,
// doing one sequential dot product and threshold compare per node until it reaches a leaf.
module odt_traverse_engine #(
    parameter int N_ATTR     = 3,
    parameter int ATTR_W     = 10,
    parameter int COEF_W     = 8,
    parameter int ACC_W      = 20,
    parameter int CLASS_W    = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32,
    parameter int MAX_HOPS   = 16,
    parameter int NODE_W     = N_ATTR*COEF_W + ACC_W + 2*(1+CLASS_W)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_we,
    input  logic [ADDR_WIDTH-1:0]         cfg_addr,
    input  logic [NODE_W-1:0]             cfg_data,
    input  logic                          start,
    input  logic [N_ATTR*ATTR_W-1:0]      attr_in,
    input  logic [ADDR_WIDTH-1:0]         root_addr,
    output logic                          busy,
    output logic                          done,
    output logic [CLASS_W-1:0]            class_out,
    output logic                          err,
    output logic [$clog2(MAX_HOPS+1)-1:0] hops_out
);

    localparam int HOP_W   = $clog2(MAX_HOPS+1);
    localparam int CHILD_W = 1 + CLASS_W;
    localparam int IDX_W   = (N_ATTR > 1) ? $clog2(N_ATTR) : 1;
    localparam int PROD_W  = COEF_W + ATTR_W + 1;
    localparam int EXT_W   = (ACC_W > PROD_W) ? ACC_W : PROD_W;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_MAC, S_DECIDE, S_FINISH, S_ABORT
    } state_t;

    state_t                    state_reg;
    logic [NODE_W-1:0]         node_mem [DEPTH];
    logic [NODE_W-1:0]         node_reg;
    logic [ADDR_WIDTH-1:0]     node_addr_reg;
    logic [N_ATTR*ATTR_W-1:0]  attr_reg;
    logic signed [ACC_W-1:0]   acc_reg;
    logic [HOP_W-1:0]          hop_reg;
    logic [IDX_W-1:0]          mac_idx_reg;
    logic [CLASS_W-1:0]        class_pend_reg;
    logic                      busy_reg;
    logic                      done_reg;
    logic                      err_reg;
    logic [CLASS_W-1:0]        class_reg;
    logic [HOP_W-1:0]          hops_reg;

    logic                      node_addr_oob;
    logic                      cfg_addr_ok;
    logic                      hop_limit;
    logic signed [COEF_W-1:0]  coef [N_ATTR];
    logic [ATTR_W-1:0]         attr [N_ATTR];
    logic signed [ACC_W-1:0]   threshold;
    logic [CHILD_W-1:0]        left_child;
    logic [CHILD_W-1:0]        right_child;
    logic [CHILD_W-1:0]        child_sel;
    logic                      child_bad;
    logic signed [PROD_W-1:0]  prod;
    logic signed [EXT_W-1:0]   prod_ext;

    // Range checks only exist when the RAM does not fill the whole address space.
    generate
        if (DEPTH < (1 << ADDR_WIDTH)) begin : g_partial_depth
            assign node_addr_oob = node_addr_reg >= ADDR_WIDTH'(DEPTH);
            assign cfg_addr_ok   = cfg_addr < ADDR_WIDTH'(DEPTH);
        end else begin : g_full_depth
            assign node_addr_oob = 1'b0;
            assign cfg_addr_ok   = 1'b1;
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < N_ATTR; gi++) begin : g_unpack
            assign coef[gi] = node_reg[NODE_W-1-gi*COEF_W -: COEF_W];
            assign attr[gi] = attr_reg[gi*ATTR_W +: ATTR_W];
        end
    endgenerate

    assign threshold   = node_reg[2*CHILD_W +: ACC_W];
    assign left_child  = node_reg[CHILD_W +: CHILD_W];
    assign right_child = node_reg[0 +: CHILD_W];
    assign hop_limit   = hop_reg == HOP_W'(MAX_HOPS);

    // Exact signed x unsigned product, sign-extended before wrapping into the accumulator.
    assign prod     = PROD_W'(coef[mac_idx_reg]) * PROD_W'($signed({1'b0, attr[mac_idx_reg]}));
    assign prod_ext = EXT_W'(prod);

    assign child_sel = (acc_reg <= threshold) ? left_child : right_child;
    assign child_bad = (child_sel[CLASS_W-1:0] >> ADDR_WIDTH) != '0;

    always_ff @(posedge clk) begin
        if (cfg_we && !busy_reg && cfg_addr_ok)
            node_mem[cfg_addr] <= cfg_data;
        if (state_reg == S_FETCH && !node_addr_oob)
            node_reg <= node_mem[node_addr_reg];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            node_addr_reg  <= '0;
            attr_reg       <= '0;
            acc_reg        <= '0;
            hop_reg        <= '0;
            mac_idx_reg    <= '0;
            class_pend_reg <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
            class_reg      <= '0;
            hops_reg       <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    // Still IDLE during the done pulse, so a start in that cycle is dropped.
                    if (start && !done_reg) begin
                        attr_reg      <= attr_in;
                        node_addr_reg <= root_addr;
                        hop_reg       <= '0;
                        err_reg       <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (node_addr_oob || hop_limit) begin
                        state_reg <= S_ABORT;
                    end else begin
                        hop_reg     <= hop_reg + HOP_W'(1);
                        acc_reg     <= '0;
                        mac_idx_reg <= '0;
                        state_reg   <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc_reg <= acc_reg + prod_ext[ACC_W-1:0];
                    if (mac_idx_reg == IDX_W'(N_ATTR-1))
                        state_reg <= S_DECIDE;
                    else
                        mac_idx_reg <= mac_idx_reg + IDX_W'(1);
                end
                S_DECIDE: begin
                    if (child_sel[CLASS_W]) begin
                        class_pend_reg <= child_sel[CLASS_W-1:0];
                        state_reg      <= S_FINISH;
                    end else if (child_bad) begin
                        state_reg <= S_ABORT;
                    end else begin
                        node_addr_reg <= child_sel[ADDR_WIDTH-1:0];
                        state_reg     <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    class_reg <= class_pend_reg;
                    hops_reg  <= hop_reg;
                    err_reg   <= 1'b0;
                    state_reg <= S_IDLE;
                end
                S_ABORT: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    class_reg <= '0;
                    hops_reg  <= hop_reg;
                    err_reg   <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign err       = err_reg;
    assign class_out = class_reg;
    assign hops_out  = hops_reg;

endmodule

// File: tb/tb_odt_traverse_engine.sv
// Bench for odt_traverse_engine: directed tree cases plus random trees against a
// tree-walking reference model.
module tb_odt_traverse_engine;

    localparam int N_ATTR     = 3;
    localparam int ATTR_W     = 10;
    localparam int COEF_W     = 8;
    localparam int ACC_W      = 20;
    localparam int CLASS_W    = 8;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 20;
    localparam int MAX_HOPS   = 16;
    localparam int NODE_W     = N_ATTR*COEF_W + ACC_W + 2*(1+CLASS_W);
    localparam int HOP_W      = $clog2(MAX_HOPS+1);
    localparam int NODE_CYC   = N_ATTR + 2;

    logic                      clk;
    logic                      rst_n;
    logic                      cfg_we;
    logic [ADDR_WIDTH-1:0]     cfg_addr;
    logic [NODE_W-1:0]         cfg_data;
    logic                      start;
    logic [N_ATTR*ATTR_W-1:0]  attr_in;
    logic [ADDR_WIDTH-1:0]     root_addr;
    logic                      busy;
    logic                      done;
    logic [CLASS_W-1:0]        class_out;
    logic                      err;
    logic [HOP_W-1:0]          hops_out;

    odt_traverse_engine #(
        .N_ATTR(N_ATTR), .ATTR_W(ATTR_W), .COEF_W(COEF_W), .ACC_W(ACC_W),
        .CLASS_W(CLASS_W), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(DEPTH), .MAX_HOPS(MAX_HOPS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .start(start), .attr_in(attr_in), .root_addr(root_addr),
        .busy(busy), .done(done), .class_out(class_out), .err(err), .hops_out(hops_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;
    logic [NODE_W-1:0] model_mem [DEPTH];

    task automatic check_val(input string tag, input int got, input int exp);
        checks_cnt++;
        if (got != exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [CLASS_W:0] leaf(input int c);
        return {1'b1, CLASS_W'(c)};
    endfunction

    function automatic logic [CLASS_W:0] ptr(input int a);
        return {1'b0, CLASS_W'(a)};
    endfunction

    function automatic logic [NODE_W-1:0] pack_node(input int c0, input int c1, input int c2,
                                                    input int thr, input logic [CLASS_W:0] l,
                                                    input logic [CLASS_W:0] r);
        return {COEF_W'(c0), COEF_W'(c1), COEF_W'(c2), ACC_W'(thr), l, r};
    endfunction

    function automatic logic [N_ATTR*ATTR_W-1:0] pack_attr(input int a0, input int a1, input int a2);
        return {ATTR_W'(a2), ATTR_W'(a1), ATTR_W'(a0)};
    endfunction

    // Walks the tree as described by the node format; also returns the expected done latency.
    function automatic void model(input int root, input logic [N_ATTR*ATTR_W-1:0] attrs,
                                  output int cls, output int e, output int hops, output int lat);
        int addr;
        int acc;
        int thr;
        logic [NODE_W-1:0] w;
        logic signed [COEF_W-1:0] cv;
        logic signed [ACC_W-1:0] tv;
        logic [CLASS_W:0] ch;
        addr = root;
        hops = 0;
        forever begin
            if (addr >= DEPTH || hops == MAX_HOPS) begin
                cls = 0; e = 1; lat = hops*NODE_CYC + 2;
                return;
            end
            w = model_mem[addr];
            hops++;
            acc = 0;
            for (int k = 0; k < N_ATTR; k++) begin
                cv = w[NODE_W-1-k*COEF_W -: COEF_W];
                acc += int'(cv) * int'(attrs[k*ATTR_W +: ATTR_W]);
            end
            acc = acc & ((1 << ACC_W) - 1);
            if (acc >= (1 << (ACC_W-1))) acc -= (1 << ACC_W);
            tv = w[2*(CLASS_W+1) +: ACC_W];
            thr = int'(tv);
            ch = (acc <= thr) ? w[CLASS_W+1 +: CLASS_W+1] : w[0 +: CLASS_W+1];
            if (ch[CLASS_W]) begin
                cls = int'(ch[CLASS_W-1:0]); e = 0; lat = hops*NODE_CYC + 1;
                return;
            end
            if (int'(ch[CLASS_W-1:0]) >= (1 << ADDR_WIDTH)) begin
                cls = 0; e = 1; lat = hops*NODE_CYC + 1;
                return;
            end
            addr = int'(ch[ADDR_WIDTH-1:0]);
        end
    endfunction

    task automatic write_node(input int addr, input logic [NODE_W-1:0] w);
        cfg_we   = 1'b1;
        cfg_addr = ADDR_WIDTH'(addr);
        cfg_data = w;
        @(posedge clk); #1;
        cfg_we   = 1'b0;
        model_mem[addr] = w;
    endtask

    // disturb: 1 = cfg write while busy, 2 = extra start while busy, 3 = start during done cycle
    task automatic run(input string tag, input int root, input logic [N_ATTR*ATTR_W-1:0] attrs,
                       input int exp_cls, input int exp_err, input int exp_hops,
                       input int exp_lat, input int disturb);
        int n;
        int extra;
        attr_in   = attrs;
        root_addr = ADDR_WIDTH'(root);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        attr_in   = (N_ATTR*ATTR_W)'($urandom);
        root_addr = ADDR_WIDTH'($urandom);
        check_val({tag, ".busy"}, int'(busy), 1);
        n = 0;
        while (!done && n < 300) begin
            if (disturb == 1 && n == 2) begin
                cfg_we   = 1'b1;
                cfg_addr = ADDR_WIDTH'(root);
                cfg_data = pack_node(0, 0, 0, 0, leaf(77), leaf(77));
            end
            if (disturb == 2 && n == 2) start = 1'b1;
            @(posedge clk); #1;
            n++;
            cfg_we = 1'b0;
            start  = 1'b0;
        end
        check_val({tag, ".class"}, int'(class_out), exp_cls);
        check_val({tag, ".err"}, int'(err), exp_err);
        check_val({tag, ".hops"}, int'(hops_out), exp_hops);
        check_val({tag, ".latency"}, n, exp_lat);
        $display("txn %s root=%0d class=%0d err=%0d hops=%0d latency=%0d",
                 tag, root, class_out, err, hops_out, n);
        if (disturb == 3) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_val({tag, ".done_one_cycle"}, int'(done), 0);
        check_val({tag, ".idle_after"}, int'(busy), 0);
        if (disturb == 2) begin
            extra = 0;
            repeat (20) begin
                @(posedge clk); #1;
                if (done) extra++;
            end
            check_val({tag, ".extra_done"}, extra, 0);
        end
    endtask

    function automatic logic [CLASS_W:0] rand_child();
        int r;
        r = $urandom_range(0, 9);
        if (r < 4) return leaf($urandom_range(0, 255));
        if (r < 9) return ptr($urandom_range(0, DEPTH + 1));
        return {1'b0, CLASS_W'($urandom_range(32, 255))};
    endfunction

    initial begin
        int cls, e, hops, lat, extra;
        logic [N_ATTR*ATTR_W-1:0] a;
        rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; attr_in = '0; root_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset.busy", int'(busy), 0);
        check_val("reset.done", int'(done), 0);
        check_val("reset.err", int'(err), 0);
        check_val("reset.class", int'(class_out), 0);
        check_val("reset.hops", int'(hops_out), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        write_node(0, pack_node(1, 1, 1, 30, leaf(5), leaf(9)));
        run("single_le", 0, pack_attr(10, 10, 10), 5, 0, 1, 6, 0);
        run("single_gt", 0, pack_attr(10, 10, 11), 9, 0, 1, 6, 0);

        write_node(0, pack_node(-1, 0, 0, -5, ptr(3), leaf(2)));
        write_node(3, pack_node(0, 2, 0, 100, leaf(7), leaf(8)));
        run("two_level", 0, pack_attr(6, 60, 0), 8, 0, 2, 11, 0);

        write_node(1, pack_node(1, 1, 1, (1 << 19) - 1, ptr(1), leaf(4)));
        run("self_loop", 1, pack_attr(1, 2, 3), 0, 1, 16, 16*NODE_CYC + 2, 0);
        run("oob_root31", 31, pack_attr(1, 2, 3), 0, 1, 0, 2, 0);
        run("oob_root20", 20, pack_attr(1, 2, 3), 0, 1, 0, 2, 0);

        write_node(2, pack_node(0, 0, 0, 0, {1'b0, 8'h23}, leaf(1)));
        run("bad_payload", 2, pack_attr(5, 5, 5), 0, 1, 1, NODE_CYC + 1, 0);

        write_node(0, pack_node(1, 1, 1, 30, leaf(5), leaf(9)));
        run("cfg_busy", 0, pack_attr(10, 10, 10), 5, 0, 1, 6, 1);
        run("cfg_rerun", 0, pack_attr(10, 10, 10), 5, 0, 1, 6, 0);
        run("start_busy", 0, pack_attr(10, 10, 11), 9, 0, 1, 6, 2);
        run("start_done", 0, pack_attr(10, 10, 10), 5, 0, 1, 6, 3);

        // Asynchronous reset while the engine is in the MAC phase
        attr_in = pack_attr(10, 10, 10); root_addr = '0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid.busy", int'(busy), 0);
        check_val("rst_mid.done", int'(done), 0);
        check_val("rst_mid.err", int'(err), 0);
        check_val("rst_mid.class", int'(class_out), 0);
        #2 rst_n = 1'b1;
        extra = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        check_val("rst_mid.no_done", extra, 0);
        write_node(0, pack_node(1, 1, 1, 30, leaf(5), leaf(9)));
        run("post_reset", 0, pack_attr(10, 10, 11), 9, 0, 1, 6, 0);

        for (int t = 0; t < 40; t++) begin
            if (t % 10 == 0) begin
                for (int i = 0; i < DEPTH; i++)
                    write_node(i, pack_node(int'($urandom_range(0, 255)) - 128,
                                            int'($urandom_range(0, 255)) - 128,
                                            int'($urandom_range(0, 255)) - 128,
                                            int'($urandom_range(0, 200000)) - 100000,
                                            rand_child(), rand_child()));
            end
            a = (N_ATTR*ATTR_W)'($urandom);
            cls = 0; e = 0; hops = 0; lat = 0;
            begin
                int root;
                root = $urandom_range(0, DEPTH + 1);
                model(root, a, cls, e, hops, lat);
                run($sformatf("rand%0d", t), root, a, cls, e, hops, lat, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
